// File: rtl/msrv32_fetch_ctrl_pkg.sv
// msrv32_fetch_ctrl_pkg
//   Shared types for the msrv32 fetch controller: PC-mux select encodings,
//   fetch FSM states, the redirect record and the redirect priority ranking.
//   No ports (package).
package msrv32_fetch_ctrl_pkg;

    // PC-mux select, value is the encoding driven on pc_src_out
    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_EPC    = 2'b01,
        PC_SRC_TRAP   = 2'b10,
        PC_SRC_BRANCH = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] BOOT_ADDRESS_DEFAULT = 32'h0000_0000;

    // One redirect: the pending slot and the arbiter result share this shape
    typedef struct packed {
        logic        valid;
        pc_src_e     src;
        logic [31:0] target;
    } redirect_t;

    // Higher value wins: trap > mret > branch
    function automatic logic [1:0] redirect_prio(input pc_src_e src);
        case (src)
            PC_SRC_TRAP:   redirect_prio = 2'd3;
            PC_SRC_EPC:    redirect_prio = 2'd2;
            PC_SRC_BRANCH: redirect_prio = 2'd1;
            default:       redirect_prio = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/msrv32_fetch_ctrl_redirect_arb.sv
// msrv32_fetch_ctrl_redirect_arb
//   Combinational redirect arbiter. Picks the highest-priority new request
//   (trap > mret > branch) and merges it with the pending slot: the higher
//   priority survives, and on equal priority the new request replaces the
//   pending one. Target bit0 is always cleared.
// Ports
//   trap_i / trap_addr_i      trap request and vector
//   mret_i / epc_i            return request and target
//   branch_i / branch_tgt_i   branch request and target
//   pend_i                    currently pending redirect
//   sel_o                     merged redirect (valid, src, target)
module msrv32_fetch_ctrl_redirect_arb
    import msrv32_fetch_ctrl_pkg::*;
(
    input  logic        trap_i,
    input  logic [31:0] trap_addr_i,
    input  logic        mret_i,
    input  logic [31:0] epc_i,
    input  logic        branch_i,
    input  logic [31:0] branch_tgt_i,
    input  redirect_t   pend_i,
    output redirect_t   sel_o
);

    redirect_t new_w;

    always_comb begin
        new_w = '0;
        if (trap_i) begin
            new_w.valid  = 1'b1;
            new_w.src    = PC_SRC_TRAP;
            new_w.target = trap_addr_i;
        end else if (mret_i) begin
            new_w.valid  = 1'b1;
            new_w.src    = PC_SRC_EPC;
            new_w.target = epc_i;
        end else if (branch_i) begin
            new_w.valid  = 1'b1;
            new_w.src    = PC_SRC_BRANCH;
            new_w.target = branch_tgt_i;
        end
        new_w.target[0] = 1'b0;

        if (new_w.valid &&
            (!pend_i.valid || (redirect_prio(new_w.src) >= redirect_prio(pend_i.src))))
            sel_o = new_w;
        else
            sel_o = pend_i;
    end

endmodule

// File: rtl/msrv32_fetch_ctrl.sv
// msrv32_fetch_ctrl
//   Program-counter sequencer for the msrv32 core. Owns the PC register,
//   drives the PC-mux select and the instruction-bus request, and holds a
//   redirect pending across AHB wait states / stalls until the PC can advance.
// Ports
//   clk_in, rst_in (async, active high)
//   ahb_ready_in, stall_in                        bus ready / pipeline hold
//   trap_taken_in, trap_address_in                trap redirect
//   mret_in, epc_in                               return redirect
//   branch_taken_in, branch_target_in             branch redirect
//   pc_out, pc_plus_4_out, iaddr_out, ireq_out    PC and fetch request
//   pc_src_out                                    PC-mux select
//   instr_valid_out, flush_out                    fetch result qualifiers
//   misaligned_instr_out                          misaligned redirect pulse
// Configuration
//   MSRV32_MISALIGN_TRAP_EN: redirect targets with bit1 set are refused (PC
//   holds, misaligned_instr_out pulses). Undefined: output tied 0.
module msrv32_fetch_ctrl
    import msrv32_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT,
    parameter int unsigned BOOT_CYCLES  = 2
)(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ahb_ready_in,
    input  logic        stall_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_address_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] iaddr_out,
    output logic        ireq_out,
    output logic [1:0]  pc_src_out,
    output logic        instr_valid_out,
    output logic        flush_out,
    output logic        misaligned_instr_out
);

    localparam int unsigned     CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    fetch_state_e     state_q;
    logic [CNT_W-1:0] boot_cnt_q;
    logic [31:0]      pc_q, pc_d;
    redirect_t        pend_q, pend_d;
    redirect_t        sel;
    logic             flush_q;
    logic             adv;
    logic             new_req;
    logic             bad_target;

    msrv32_fetch_ctrl_redirect_arb u_arb (
        .trap_i       (trap_taken_in),
        .trap_addr_i  (trap_address_in),
        .mret_i       (mret_in),
        .epc_i        (epc_in),
        .branch_i     (branch_taken_in),
        .branch_tgt_i (branch_target_in),
        .pend_i       (pend_q),
        .sel_o        (sel)
    );

    assign ireq_out      = (state_q != S_BOOT);
    assign adv           = ireq_out & ahb_ready_in & ~stall_in;
    assign new_req       = trap_taken_in | mret_in | branch_taken_in;
    assign pc_out        = pc_q;
    assign iaddr_out     = pc_q;
    assign pc_plus_4_out = pc_q + 32'd4;
    assign flush_out     = flush_q;
    assign pc_src_out    = (adv && sel.valid) ? sel.src : PC_SRC_SEQ;
    // A pending redirect applied now also invalidates the word returned this cycle
    assign instr_valid_out = adv & ~flush_q & ~sel.valid;

`ifdef MSRV32_MISALIGN_TRAP_EN
    logic misal_q;

    assign bad_target           = sel.valid & sel.target[1];
    assign misaligned_instr_out = misal_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            misal_q <= 1'b0;
        else
            misal_q <= adv & bad_target;
    end
`else
    assign bad_target           = 1'b0;
    assign misaligned_instr_out = 1'b0;
`endif

    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        if (adv) begin
            // the pending slot is consumed (or refused) on every advance
            pend_d = '0;
            if (!sel.valid)
                pc_d = pc_q + 32'd4;
            else if (!bad_target)
                pc_d = sel.target;
        end else begin
            pend_d = sel;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= '0;
            pc_q       <= BOOT_ADDRESS;
            pend_q     <= '0;
            flush_q    <= 1'b0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    if (boot_cnt_q == BOOT_LAST)
                        state_q <= S_RUN;
                    else
                        boot_cnt_q <= boot_cnt_q + CNT_W'(1);
                end
                S_RUN:   if (!ahb_ready_in) state_q <= S_WAIT;
                S_WAIT:  if (ahb_ready_in)  state_q <= S_RUN;
                default: state_q <= S_BOOT;
            endcase
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            flush_q <= new_req;
        end
    end

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// tb_msrv32_fetch_ctrl
//   Self-checking bench for msrv32_fetch_ctrl: directed scenarios plus a
//   randomized run checked against a behavioural model of the PC sequencer.
module tb_msrv32_fetch_ctrl;

    localparam logic [31:0] BOOT = 32'h0000_0000;
    localparam int          BOOT_CYC = 2;
`ifdef MSRV32_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ready, stall, trap, mret, br;
    logic [31:0] trap_addr, epc, bt;
    logic [31:0] pc, p4, iaddr;
    logic        ireq, ivalid, flush, mis;
    logic [1:0]  src;

    int tests_run    = 0;
    int tests_failed = 0;

    msrv32_fetch_ctrl #(.BOOT_ADDRESS(BOOT), .BOOT_CYCLES(BOOT_CYC)) dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .ahb_ready_in         (ready),
        .stall_in             (stall),
        .trap_taken_in        (trap),
        .trap_address_in      (trap_addr),
        .mret_in              (mret),
        .epc_in               (epc),
        .branch_taken_in      (br),
        .branch_target_in     (bt),
        .pc_out               (pc),
        .pc_plus_4_out        (p4),
        .iaddr_out            (iaddr),
        .ireq_out             (ireq),
        .pc_src_out           (src),
        .instr_valid_out      (ivalid),
        .flush_out            (flush),
        .misaligned_instr_out (mis)
    );

    always #5 clk = ~clk;

    // Behavioural model: PC, boot countdown, one pending redirect (by rank)
    logic [31:0] m_pc, p_tgt, n_pc, n_tgt;
    int          m_boot_left, p_rank, n_rank;
    bit          m_flush, m_mis, n_flush, n_mis;
    bit          e_ireq, e_adv, e_valid;
    logic [1:0]  e_src;

    function automatic logic [1:0] rank_code(input int r);
        case (r)
            3:       return 2'b10;
            2:       return 2'b01;
            1:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = BOOT; m_boot_left = BOOT_CYC; m_flush = 0; m_mis = 0;
        p_rank = 0; p_tgt = '0;
    endtask

    task automatic model_eval();
        int          nr, sr;
        logic [31:0] nt, st;
        nr = 0; nt = '0;
        if (trap)      begin nr = 3; nt = trap_addr; end
        else if (mret) begin nr = 2; nt = epc; end
        else if (br)   begin nr = 1; nt = bt; end
        nt[0] = 1'b0;
        if (nr != 0 && nr >= p_rank) begin sr = nr; st = nt; end
        else begin sr = p_rank; st = p_tgt; end
        e_ireq  = (m_boot_left == 0);
        e_adv   = e_ireq && ready && !stall;
        e_src   = (e_adv && sr != 0) ? rank_code(sr) : 2'b00;
        e_valid = e_adv && !m_flush && sr == 0;
        n_flush = trap || mret || br;
        n_mis = 0; n_pc = m_pc; n_rank = p_rank; n_tgt = p_tgt;
        if (e_adv) begin
            n_rank = 0;
            if (sr == 0)              n_pc = m_pc + 32'd4;
            else if (MIS_EN && st[1]) n_mis = 1;
            else                      n_pc = st;
        end else begin
            n_rank = sr; n_tgt = st;
        end
    endtask

    task automatic drive(input bit tr, input logic [31:0] ta, input bit mr,
                         input logic [31:0] ep, input bit b, input logic [31:0] bta,
                         input bit rdy, input bit st);
        trap = tr; trap_addr = ta; mret = mr; epc = ep; br = b; bt = bta;
        ready = rdy; stall = st;
        #1;
        model_eval();
    endtask

    task automatic idle(input bit rdy);
        drive(0, '0, 0, '0, 0, '0, rdy, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        m_pc = n_pc; p_rank = n_rank; p_tgt = n_tgt; m_flush = n_flush; m_mis = n_mis;
        if (m_boot_left > 0) m_boot_left--;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(1);
        model_reset();
        tests_run++;
        if (pc !== BOOT || ireq !== 1'b0 || ivalid !== 1'b0 || flush !== 1'b0 || src !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset: pc=%h ireq=%b valid=%b flush=%b src=%b, want pc=%h 0 0 0 00",
                     pc, ireq, ivalid, flush, src, BOOT);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_boot_seq();
        for (int c = 0; c < 5; c++) begin
            idle(1);
            tests_run++;
            if (ireq !== (c >= BOOT_CYC)) begin
                tests_failed++;
                $display("FAIL boot_ireq c=%0d: got %b want %b", c, ireq, c >= BOOT_CYC);
            end
            if (c >= BOOT_CYC) begin
                tests_run++;
                if (iaddr !== 32'(4 * (c - BOOT_CYC)) || ivalid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL boot_seq c=%0d: iaddr=%h valid=%b want %h 1",
                             c, iaddr, ivalid, 32'(4 * (c - BOOT_CYC)));
                end
            end
            if (c < 4) tick();
        end
    endtask

    task automatic test_branch();
        drive(0, '0, 0, '0, 1, 32'h100, 1, 0);
        tests_run++;
        if (pc !== 32'h8 || src !== 2'b11 || ivalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL branch_sel: pc=%h src=%b valid=%b want 8 11 0", pc, src, ivalid);
        end
        tick(); idle(1);
        tests_run++;
        if (iaddr !== 32'h100 || flush !== 1'b1 || src !== 2'b00) begin
            tests_failed++;
            $display("FAIL branch_redir: iaddr=%h flush=%b src=%b want 100 1 00", iaddr, flush, src);
        end
        tick(); idle(1);
        tests_run++;
        if (iaddr !== 32'h104 || flush !== 1'b0 || ivalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_after: iaddr=%h flush=%b valid=%b want 104 0 1", iaddr, flush, ivalid);
        end
        tick();
    endtask

    task automatic test_branch_wait();
        drive(0, '0, 0, '0, 1, 32'h100, 0, 0);
        tests_run++;
        if (src !== 2'b00 || iaddr !== 32'h108) begin
            tests_failed++;
            $display("FAIL wait_capture: src=%b iaddr=%h want 00 108", src, iaddr);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            idle(0);
            tests_run++;
            if (iaddr !== 32'h108 || flush !== (c == 0) || ireq !== 1'b1) begin
                tests_failed++;
                $display("FAIL wait_hold c=%0d: iaddr=%h flush=%b ireq=%b want 108 %b 1",
                         c, iaddr, flush, ireq, c == 0);
            end
            tick();
        end
        idle(1);
        tests_run++;
        if (src !== 2'b11 || ivalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_apply: src=%b valid=%b want 11 0", src, ivalid);
        end
        tick(); idle(1);
        tests_run++;
        if (iaddr !== 32'h100 || flush !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_target: iaddr=%h flush=%b want 100 0", iaddr, flush);
        end
        tick();
    endtask

    task automatic test_trap_mret();
        drive(1, 32'h80, 0, '0, 1, 32'h100, 1, 0);
        tests_run++;
        if (src !== 2'b10) begin
            tests_failed++;
            $display("FAIL trap_prio: src=%b want 10", src);
        end
        tick(); idle(1);
        tests_run++;
        if (pc !== 32'h80 || flush !== 1'b1) begin
            tests_failed++;
            $display("FAIL trap_pc: pc=%h flush=%b want 80 1", pc, flush);
        end
        tick();
        drive(0, '0, 1, 32'h200, 0, '0, 1, 0);
        tests_run++;
        if (src !== 2'b01) begin
            tests_failed++;
            $display("FAIL mret_sel: src=%b want 01", src);
        end
        tick(); idle(1);
        tests_run++;
        if (pc !== 32'h200) begin
            tests_failed++;
            $display("FAIL mret_pc: pc=%h want 200", pc);
        end
        tick();
    endtask

    task automatic test_wrap_stall();
        drive(0, '0, 0, '0, 1, 32'hFFFF_FFFC, 1, 0);
        tick(); idle(1);
        tests_run++;
        if (pc !== 32'hFFFF_FFFC || p4 !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_p4: pc=%h p4=%h want fffffffc 0", pc, p4);
        end
        tick();
        drive(0, '0, 0, '0, 0, '0, 1, 1);
        tests_run++;
        if (pc !== 32'h0 || ivalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_stall: pc=%h valid=%b want 0 0", pc, ivalid);
        end
        tick(); idle(1);
        tests_run++;
        if (pc !== 32'h0 || ivalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_hold: pc=%h valid=%b want 0 1", pc, ivalid);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        idle(0); tick();
        drive(0, '0, 0, '0, 1, 32'h300, 0, 0);
        tick();
        idle(0);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (pc !== BOOT || ireq !== 1'b0 || flush !== 1'b0 || src !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_async: pc=%h ireq=%b flush=%b src=%b want %h 0 0 00",
                     pc, ireq, flush, src, BOOT);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < BOOT_CYC + 2; c++) begin
            idle(1);
            if (c >= BOOT_CYC) begin
                tests_run++;
                if (iaddr !== BOOT + 32'(4 * (c - BOOT_CYC)) || src !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL rst_pend_lost c=%0d: iaddr=%h src=%b want %h 00",
                             c, iaddr, src, BOOT + 32'(4 * (c - BOOT_CYC)));
                end
            end
            tick();
        end
    endtask

`ifdef MSRV32_MISALIGN_TRAP_EN
    task automatic test_misalign();
        logic [31:0] p0;
        idle(1);
        p0 = pc;
        tick();
        drive(0, '0, 0, '0, 1, 32'h102, 1, 0);
        tick(); idle(1);
        tests_run++;
        if (pc !== p0 + 32'd4 || mis !== 1'b1) begin
            tests_failed++;
            $display("FAIL misalign_hold: pc=%h mis=%b want %h 1", pc, mis, p0 + 32'd4);
        end
        tick(); idle(1);
        tests_run++;
        if (mis !== 1'b0 || pc !== p0 + 32'd8) begin
            tests_failed++;
            $display("FAIL misalign_pulse: pc=%h mis=%b want %h 0", pc, mis, p0 + 32'd8);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive(($urandom % 10) == 0, $urandom, ($urandom % 10) == 0, $urandom,
                  ($urandom % 5) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 6) == 0);
            tests_run++;
            if (pc !== m_pc || iaddr !== m_pc || p4 !== m_pc + 32'd4) begin
                tests_failed++;
                $display("FAIL rand_pc c=%0d: pc=%h iaddr=%h p4=%h want pc=%h", c, pc, iaddr, p4, m_pc);
            end
            tests_run++;
            if ({ireq, src, ivalid, flush, mis} !== {e_ireq, e_src, e_valid, m_flush, m_mis}) begin
                tests_failed++;
                $display("FAIL rand_ctl c=%0d: ireq/src/valid/flush/mis=%b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         c, ireq, src, ivalid, flush, mis, e_ireq, e_src, e_valid, m_flush, m_mis);
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        trap = 0; mret = 0; br = 0; trap_addr = '0; epc = '0; bt = '0;
        ready = 1; stall = 0;
        @(negedge clk);
        test_reset();
        test_boot_seq();
        test_branch();
        test_branch_wait();
        test_trap_mret();
        test_wrap_stall();
        test_reset_mid_wait();
`ifdef MSRV32_MISALIGN_TRAP_EN
        test_misalign();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
